// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage MIPS core: word/register widths, EX/MEM state and latched fields.
package cpu_types_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } exmem_state_t;

  typedef struct packed {
    logic     dren;
    logic     dwen;
    logic     wen;
    logic     memtoreg;
    logic     halt;
    regbits_t wsel;
    word_t    aluout;
    word_t    rdat2;
    word_t    pcp4;
    word_t    dload;
  } exmem_t;

endpackage

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: latches EX results, issues the data-memory request and stalls until dhit.
// Optional forwarding outputs (fwd_valid/fwd_wsel/fwd_data) are built when EX_MEM_FWD_EN is defined.
//
//  state  | meaning
//  IDLE   | no access outstanding, latch may load on ihit
//  ACCESS | memory request driven, upstream stalled until dhit
//  DONE   | access finished, result held for MEM/WB until next load
module ex_mem_latch
  import cpu_types_pkg::*;
(
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  flush,
  input  logic                  dREN_in,
  input  logic                  dWEN_in,
  input  logic                  WEN_in,
  input  logic                  MemtoReg_in,
  input  logic                  halt_in,
  input  logic [REG_ADDR_W-1:0] wsel_in,
  input  logic [WORD_W-1:0]     aluout_in,
  input  logic [WORD_W-1:0]     rdat2_in,
  input  logic [WORD_W-1:0]     pcp4_in,
  input  logic [WORD_W-1:0]     dmemload,
  output logic                  dREN_out,
  output logic                  dWEN_out,
  output logic [WORD_W-1:0]     dmemaddr,
  output logic [WORD_W-1:0]     dmemstore,
  output logic                  WEN_out,
  output logic                  MemtoReg_out,
  output logic                  halt_out,
  output logic [REG_ADDR_W-1:0] wsel_out,
  output logic [WORD_W-1:0]     aluout_out,
  output logic [WORD_W-1:0]     pcp4_out,
  output logic [WORD_W-1:0]     dload_out,
`ifdef EX_MEM_FWD_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_wsel,
  output logic [WORD_W-1:0]     fwd_data,
`endif
  output logic                  mem_busy
);

  exmem_state_t state, nxt_state;
  exmem_t       r, nxt;
  logic         en;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      r     <= '0;
    end else begin
      state <= nxt_state;
      r     <= nxt;
    end
  end

  // A latched HALT freezes the whole register until reset.
  assign en = ihit & ~mem_busy & ~r.halt;

  always_comb begin
    nxt_state = state;
    nxt       = r;
    case (state)
      IDLE, DONE: begin
        if (en) begin
          if (flush) begin
            nxt       = '0;
            nxt_state = IDLE;
          end else begin
            nxt.dren     = dREN_in;
            nxt.dwen     = dWEN_in;
            nxt.wen      = WEN_in;
            nxt.memtoreg = MemtoReg_in;
            nxt.halt     = halt_in;
            nxt.wsel     = wsel_in;
            nxt.aluout   = aluout_in;
            nxt.rdat2    = rdat2_in;
            nxt.pcp4     = pcp4_in;
            nxt.dload    = '0;
            nxt_state    = (dREN_in | dWEN_in) ? ACCESS : IDLE;
          end
        end
      end
      ACCESS: begin
        if (dhit) begin
          nxt_state = DONE;
          if (r.dren) nxt.dload = dmemload;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign mem_busy     = (state == ACCESS);
  assign dREN_out     = mem_busy & r.dren;
  assign dWEN_out     = mem_busy & r.dwen;
  assign dmemaddr     = r.aluout;
  assign dmemstore    = r.rdat2;
  assign WEN_out      = r.wen;
  assign MemtoReg_out = r.memtoreg;
  assign halt_out     = r.halt;
  assign wsel_out     = r.wsel;
  assign aluout_out   = r.aluout;
  assign pcp4_out     = r.pcp4;
  assign dload_out    = r.dload;

`ifdef EX_MEM_FWD_EN
  // A load still in flight has no data to forward yet.
  assign fwd_valid = r.wen & (r.wsel != '0) & ~(r.memtoreg & mem_busy);
  assign fwd_wsel  = r.wsel;
  assign fwd_data  = r.memtoreg ? r.dload : r.aluout;
`endif

endmodule
